// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART TX channel
// between NUM_REQ byte-stream requesters.
module uart_tx_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int HOLD_CYCLES = 4,
   parameter int ACK_TIMEOUT = 64
) (
   input  logic                       clk_50_mhz,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [8*NUM_REQ-1:0]       req_data,
   input  logic [NUM_REQ-1:0]         req_last,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic [7:0]                 uart_din,
   output logic                       uart_wr_en,
   input  logic                       uart_tx_busy,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       grant_active,
   output logic                       err_timeout
);

   localparam int IDW  = $clog2(NUM_REQ);
   localparam int CMAX = (HOLD_CYCLES > ACK_TIMEOUT) ?
                         HOLD_CYCLES : ACK_TIMEOUT;
   localparam int CNTW = $clog2(CMAX) + 1;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      STROBE,
      SETTLE
   } state_t;

   state_t          state_q, state_d;
   logic [IDW-1:0]  gid_q, gid_d;
   logic [IDW-1:0]  rr_q, rr_d;
   logic            gact_q, gact_d;
   logic [7:0]      din_q, din_d;
   logic            last_q, last_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic            wr_q, wr_d;
   logic            err_q, err_d;

   logic [IDW-1:0]  pick;
   logic [IDW-1:0]  idx;
   logic            found;
   logic            done;

   // Search starts one past the previous owner so it goes last.
   always_comb begin
      pick  = '0;
      idx   = '0;
      found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = IDW'((int'(rr_q) + k) % NUM_REQ);
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      gid_d     = gid_q;
      rr_d      = rr_q;
      gact_d    = gact_q;
      din_d     = din_q;
      last_d    = last_q;
      cnt_d     = cnt_q;
      wr_d      = wr_q;
      err_d     = 1'b0;
      done      = 1'b0;
      req_ready = '0;
      unique case (state_q)
         IDLE: begin
            if (|req_valid) begin
               gid_d   = pick;
               gact_d  = 1'b1;
               state_d = LOAD;
            end
         end
         LOAD: begin
            if (req_valid[gid_q] && !uart_tx_busy) begin
               req_ready[gid_q] = 1'b1;
               din_d   = req_data[{gid_q, 3'b000} +: 8];
               last_d  = req_last[gid_q];
               cnt_d   = '0;
               wr_d    = 1'b1;
               state_d = STROBE;
            end
         end
         STROBE: begin
            if (cnt_q == CNTW'(HOLD_CYCLES - 1)) begin
               wr_d    = 1'b0;
               cnt_d   = '0;
               state_d = SETTLE;
            end else begin
               cnt_d = cnt_q + CNTW'(1);
            end
         end
         SETTLE: begin
            if (uart_tx_busy) begin
               done = 1'b1;
            end else if (cnt_q == CNTW'(ACK_TIMEOUT - 1)) begin
               err_d = 1'b1;
               done  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNTW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      if (done) begin
         if (last_q) begin
            rr_d    = gid_q;
            gact_d  = 1'b0;
            state_d = IDLE;
         end else begin
            state_d = LOAD;
         end
      end
   end

   always_ff @(posedge clk_50_mhz or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         gid_q   <= '0;
         rr_q    <= IDW'(NUM_REQ - 1);
         gact_q  <= 1'b0;
         din_q   <= '0;
         last_q  <= 1'b0;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         gid_q   <= gid_d;
         rr_q    <= rr_d;
         gact_q  <= gact_d;
         din_q   <= din_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         err_q   <= err_d;
      end
   end

   assign uart_din     = din_q;
   assign uart_wr_en   = wr_q;
   assign grant_id     = gid_q;
   assign grant_active = gact_q;
   assign err_timeout  = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester queues, a simple
// UART busy model and an in-order scoreboard of transmitted bytes.
module tb_uart_tx_arbiter;

   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req_valid = '0;
   logic [8*N-1:0] req_data  = '0;
   logic [N-1:0]   req_last  = '0;
   logic [N-1:0]   req_ready;
   logic [7:0]     uart_din;
   logic           uart_wr_en;
   logic           uart_tx_busy;
   logic [1:0]     grant_id;
   logic           grant_active;
   logic           err_timeout;

   int errors = 0;
   int checks = 0;

   logic [8:0] rq [N][$];
   bit         pend [N];
   int         rdy_cnt [N];
   logic [9:0] sb [$];
   logic [9:0] sb_e;
   logic [8:0] rq_e;
   logic [N-1:0] exp_rdy;

   int  busy_cnt   = 0;
   int  busy_len   = 10;
   bit  model_on   = 1'b1;
   bit  force_busy = 1'b0;
   bit  m_prev     = 1'b0;
   int  run        = 0;
   bit  wprev      = 1'b0;
   logic [7:0] din_cap = '0;

   always #10 clk = ~clk;

   assign uart_tx_busy = (busy_cnt != 0) || force_busy;

   uart_tx_arbiter #(
      .NUM_REQ    (N),
      .HOLD_CYCLES(4),
      .ACK_TIMEOUT(64)
   ) dut (
      .clk_50_mhz  (clk),
      .reset       (rst),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_last    (req_last),
      .req_ready   (req_ready),
      .uart_din    (uart_din),
      .uart_wr_en  (uart_wr_en),
      .uart_tx_busy(uart_tx_busy),
      .grant_id    (grant_id),
      .grant_active(grant_active),
      .err_timeout (err_timeout)
   );

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit all_idle();
      bit r = (sb.size() == 0) && !grant_active;
      for (int i = 0; i < N; i++)
         if (rq[i].size() != 0 || pend[i]) r = 1'b0;
      return r;
   endfunction

   task automatic wait_done(string tag, int budget);
      bit ok = 1'b0;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (all_idle()) begin
            ok = 1'b1;
            break;
         end
      end
      chk(tag, 32'(ok), 32'd1);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Accepts are sampled where the DUT acts on them.
   always @(posedge clk) begin
      if (!rst && req_ready != '0) begin
         exp_rdy = '0;
         exp_rdy[grant_id] = 1'b1;
         chk("ready_onehot", 32'(req_ready), 32'(exp_rdy));
         for (int i = 0; i < N; i++)
            if (req_ready[i]) begin
               pend[i] = 1'b1;
               rdy_cnt[i]++;
            end
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (pend[i]) begin
            if (rq[i].size() > 0) rq_e = rq[i].pop_front();
            pend[i] = 1'b0;
         end
         if (rq[i].size() > 0) begin
            rq_e = rq[i][0];
            req_valid[i]       = 1'b1;
            req_data[8*i +: 8] = rq_e[7:0];
            req_last[i]        = rq_e[8];
         end else begin
            req_valid[i] = 1'b0;
            req_last[i]  = 1'b0;
         end
      end
      if (busy_cnt > 0) busy_cnt--;
      if (model_on && uart_wr_en && !m_prev) busy_cnt = busy_len;
      m_prev = uart_wr_en;
      if (rst) begin
         run   = 0;
         wprev = 1'b0;
      end else begin
         if (uart_wr_en && !wprev) begin
            din_cap = uart_din;
            if (sb.size() == 0) begin
               chk("sb_unexpected", 32'd1, 32'd0);
            end else begin
               sb_e = sb.pop_front();
               chk("sb_din", 32'(uart_din), 32'(sb_e[7:0]));
               chk("sb_gid", 32'(grant_id), 32'(sb_e[9:8]));
            end
         end
         if (uart_wr_en) run++;
         if (!uart_wr_en && wprev) begin
            chk("wr_len", 32'(run), 32'd4);
            chk("din_stable", 32'(uart_din), 32'(din_cap));
            run = 0;
         end
         wprev = uart_wr_en;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int b0, b2, k, bad;
      bit ok;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_wr_en", 32'(uart_wr_en), 32'd0);
      chk("rst_din", 32'(uart_din), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_gact", 32'(grant_active), 32'd0);
      chk("rst_gid", 32'(grant_id), 32'd0);
      chk("rst_err", 32'(err_timeout), 32'd0);
      rst = 1'b0;

      // 1: single requester, 3-byte packet
      @(posedge clk);
      b0 = rdy_cnt[0];
      rq[0].push_back(9'h041);
      rq[0].push_back(9'h042);
      rq[0].push_back(9'h143);
      sb.push_back({2'd0, 8'h41});
      sb.push_back({2'd0, 8'h42});
      sb.push_back({2'd0, 8'h43});
      wait_done("t1_done", 500);
      chk("t1_ready_cnt", 32'(rdy_cnt[0] - b0), 32'd3);
      chk("t1_gact_low", 32'(grant_active), 32'd0);

      // 2: all request from reset, round-robin order
      pulse_reset();
      @(posedge clk);
      rq[0].push_back(9'h1A0);
      rq[0].push_back(9'h1A1);
      rq[1].push_back(9'h1B1);
      rq[2].push_back(9'h1C2);
      rq[3].push_back(9'h1D3);
      sb.push_back({2'd0, 8'hA0});
      sb.push_back({2'd1, 8'hB1});
      sb.push_back({2'd2, 8'hC2});
      sb.push_back({2'd3, 8'hD3});
      sb.push_back({2'd0, 8'hA1});
      wait_done("t2_done", 800);

      // 3: req2 arrives mid-packet of req0
      @(posedge clk);
      b0 = rdy_cnt[0];
      b2 = rdy_cnt[2];
      rq[0].push_back(9'h010);
      rq[0].push_back(9'h111);
      sb.push_back({2'd0, 8'h10});
      sb.push_back({2'd0, 8'h11});
      sb.push_back({2'd2, 8'h20});
      ok = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (rdy_cnt[0] == b0 + 1) begin
            ok = 1'b1;
            break;
         end
      end
      chk("t3_first_acc", 32'(ok), 32'd1);
      @(posedge clk);
      rq[2].push_back(9'h120);
      ok = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (rdy_cnt[0] == b0 + 2) begin
            ok = 1'b1;
            break;
         end
      end
      chk("t3_second_acc", 32'(ok), 32'd1);
      chk("t3_no_r2_early", 32'(rdy_cnt[2] - b2), 32'd0);
      wait_done("t3_done", 500);
      chk("t3_r2_acc", 32'(rdy_cnt[2] - b2), 32'd1);

      // 4: busy held high in LOAD
      @(negedge clk);
      force_busy = 1'b1;
      @(posedge clk);
      rq[1].push_back(9'h155);
      sb.push_back({2'd1, 8'h55});
      ok = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (grant_active) begin
            ok = 1'b1;
            break;
         end
      end
      chk("t4_granted", 32'(ok), 32'd1);
      bad = 0;
      repeat (50) begin
         @(negedge clk);
         if (uart_wr_en || req_ready != '0) bad++;
      end
      chk("t4_hold", 32'(bad), 32'd0);
      chk("t4_gid", 32'(grant_id), 32'd1);
      force_busy = 1'b0;
      #1;
      chk("t4_accept", 32'(req_ready), 32'h2);
      wait_done("t4_done", 300);

      // 5: UART never acknowledges
      model_on = 1'b0;
      @(posedge clk);
      rq[3].push_back(9'h177);
      sb.push_back({2'd3, 8'h77});
      ok = 1'b0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (uart_wr_en) begin
            ok = 1'b1;
            break;
         end
      end
      chk("t5_wr_rise", 32'(ok), 32'd1);
      ok = 1'b0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (!uart_wr_en) begin
            ok = 1'b1;
            break;
         end
      end
      chk("t5_wr_fall", 32'(ok), 32'd1);
      k = 0;
      while (!err_timeout && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("t5_err_latency", 32'(k), 32'd64);
      chk("t5_gact_low", 32'(grant_active), 32'd0);
      @(negedge clk);
      chk("t5_err_pulse", 32'(err_timeout), 32'd0);
      model_on = 1'b1;
      @(posedge clk);
      rq[0].push_back(9'h199);
      sb.push_back({2'd0, 8'h99});
      wait_done("t5_recover", 300);

      // 6: reset mid-strobe
      @(posedge clk);
      rq[2].push_back(9'h1A5);
      sb.push_back({2'd2, 8'hA5});
      ok = 1'b0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (uart_wr_en) begin
            ok = 1'b1;
            break;
         end
      end
      chk("t6_wr_rise", 32'(ok), 32'd1);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("t6_wr_en", 32'(uart_wr_en), 32'd0);
      chk("t6_ready", 32'(req_ready), 32'd0);
      chk("t6_gact", 32'(grant_active), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      rq[3].push_back(9'h133);
      rq[0].push_back(9'h130);
      sb.push_back({2'd0, 8'h30});
      sb.push_back({2'd3, 8'h33});
      wait_done("t6_done", 500);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
